systolic_skew_stream: RTL and testbench

SYSTOLIC_SKEW_STREAM -- requirements
Module: systolic_skew_stream

---
 rtl/systolic_skew_stream_pkg.sv | 6 +
 rtl/systolic_skew_stream_if.sv | 12 +
 rtl/systolic_skew_stream_delay_line.sv | 25 ++
 rtl/systolic_skew_stream.sv | 59 +++++
 tb/tb_systolic_skew_stream.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/systolic_skew_stream_pkg.sv
// systolic_skew_stream_pkg: FSM states and mode encodings shared by the skew/deskew stream block
package systolic_skew_stream_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;
  localparam logic SKEW = 1'b0;
  localparam logic DESKEW = 1'b1;
endpackage

// File: rtl/systolic_skew_stream_if.sv
// systolic_skew_stream_if: one valid/ready vector stream, LANES elements of DATA_BITS each
interface systolic_skew_stream_if #(
  parameter int DATA_BITS = 8,
  parameter int LANES = 16
);
  logic valid;
  logic ready;
  logic last;
  logic [LANES-1:0][DATA_BITS-1:0] data;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/systolic_skew_stream_delay_line.sv
// systolic_delay_line: zero-reset shift register with a runtime tap; tap 0 passes din straight through
module systolic_delay_line #(
  parameter int DATA_BITS = 8,
  parameter int MAX_DEPTH = 1,
  localparam int TAP_BITS = $clog2(MAX_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 en,
  input  logic [TAP_BITS-1:0]  tap,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] dout
);
  logic [MAX_DEPTH-1:0][DATA_BITS-1:0] stage;
  always_ff @(posedge clock or negedge reset)
    if (!reset) stage <= '0;
    else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < MAX_DEPTH; i++) stage[i] <= stage[i-1];
    end
  always_comb begin
    dout = din;
    for (int i = 1; i <= MAX_DEPTH; i++) if (tap == TAP_BITS'(i)) dout = stage[i-1];
  end
endmodule

// File: rtl/systolic_skew_stream.sv
// systolic_skew_stream: skews (lane k late by k beats) or deskews (late by LANES-1-k) a vector stream,
// then drains LANES-1 zero-filled beats so every frame leaves the array completely.
module systolic_skew_stream
  import systolic_skew_stream_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int LANES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mode,
  systolic_skew_stream_if.slave  in_s,
  systolic_skew_stream_if.master out_s
);
  localparam int CNT_BITS = LANES > 1 ? $clog2(LANES) : 1;
  state_t state;
  logic mode_q;
  logic eff_mode;
  logic step;
  logic [CNT_BITS-1:0] cnt;
  assign step = state == DRAIN ? out_s.ready : in_s.valid && out_s.ready;
  assign in_s.ready = state != DRAIN && out_s.ready;
  assign out_s.valid = state == DRAIN || in_s.valid;
  assign out_s.last = reset && (state == DRAIN ? cnt == CNT_BITS'(1) : LANES == 1 && in_s.valid && in_s.last);
  // the first beat of a frame already needs its taps, so IDLE uses the live mode
  assign eff_mode = state == IDLE ? mode : mode_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      mode_q <= SKEW;
    end else if (step) begin
      if (state == IDLE) mode_q <= mode;
      if (state == DRAIN) begin
        cnt <= cnt - 1'b1;
        state <= cnt == CNT_BITS'(1) ? IDLE : DRAIN;
      end else if (in_s.last) begin
        state <= LANES > 1 ? DRAIN : IDLE;
        cnt <= CNT_BITS'(LANES - 1);
      end else state <= STREAM;
    end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int MD_RAW = k > LANES - 1 - k ? k : LANES - 1 - k;
    localparam int MD = MD_RAW < 1 ? 1 : MD_RAW;
    localparam int TW = $clog2(MD + 1);
    logic [TW-1:0] tap;
    logic [DATA_BITS-1:0] din;
    assign tap = eff_mode == DESKEW ? TW'(LANES - 1 - k) : TW'(k);
    assign din = state == DRAIN ? '0 : in_s.data[k];
    systolic_delay_line #(.DATA_BITS(DATA_BITS), .MAX_DEPTH(MD)) u_line (
      .clock(clock),
      .reset(reset),
      .en(step),
      .tap(tap),
      .din(din),
      .dout(out_s.data[k])
    );
  end
endmodule

// File: tb/tb_systolic_skew_stream.sv
// tb_systolic_skew_stream: directed scoreboard bench for a 4-lane and a 1-lane instance
module tb_systolic_skew_stream;
  import systolic_skew_stream_pkg::*;
  localparam int DB = 8;
  localparam int L = 4;
  typedef logic [L-1:0][DB-1:0] vec_t;
  typedef struct packed {vec_t data; logic last; logic m; logic first;} beat_t;
  typedef struct packed {vec_t data; logic last;} exp_t;
  logic clock = 0;
  logic reset = 0;
  logic mode = 0;
  logic mode1 = 0;
  beat_t in_q[$];
  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc;
  int beats;
  int want;
  always #5 clock = ~clock;
  systolic_skew_stream_if #(.DATA_BITS(DB), .LANES(L)) in4 ();
  systolic_skew_stream_if #(.DATA_BITS(DB), .LANES(L)) out4 ();
  systolic_skew_stream_if #(.DATA_BITS(DB), .LANES(1)) in1 ();
  systolic_skew_stream_if #(.DATA_BITS(DB), .LANES(1)) out1 ();
  systolic_skew_stream #(.DATA_BITS(DB), .LANES(L)) dut4 (
    .clock(clock), .reset(reset), .mode(mode), .in_s(in4.slave), .out_s(out4.master));
  systolic_skew_stream #(.DATA_BITS(DB), .LANES(1)) dut1 (
    .clock(clock), .reset(reset), .mode(mode1), .in_s(in1.slave), .out_s(out1.master));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected beat t, lane k = input beat t-d(k), zero outside the frame
  task automatic add_frame(input int n, input int base, input logic m);
    vec_t v[$];
    vec_t x;
    vec_t y;
    int s;
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < L; k++) x[k] = DB'(base + 10 * t + k);
      v.push_back(x);
      in_q.push_back('{x, t == n - 1, m, t == 0});
    end
    for (int t = 0; t < n + L - 1; t++) begin
      for (int k = 0; k < L; k++) begin
        s = t - (m ? L - 1 - k : k);
        y[k] = (s >= 0 && s < n) ? v[s][k] : '0;
      end
      exp_q.push_back('{y, t == n + L - 2});
    end
  endtask

  task automatic run(input int s0, input int s1, input bit wobble, input int limit, input bit must_finish,
                     output int cycles, output int nbeats);
    vec_t prev = '0;
    bit stalled_prev = 0;
    exp_t e;
    cycles = 0;
    nbeats = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && cycles < limit) begin
      @(posedge clock);
      #1;
      out4.ready = !((cycles >= s0 && cycles < s0 + 3) || (cycles >= s1 && cycles < s1 + 3));
      in4.valid = in_q.size() != 0;
      if (in_q.size() != 0) begin
        in4.data = in_q[0].data;
        in4.last = in_q[0].last;
        mode = in_q[0].m ^ (wobble && !in_q[0].first && cycles[0]);
      end else begin
        in4.data = '0;
        in4.last = 0;
      end
      @(negedge clock);
      if (!out4.ready) begin
        check("stall_in_ready", in4.ready, 0);
        if (stalled_prev) check("stall_hold", out4.data, prev);
      end
      stalled_prev = !out4.ready;
      prev = out4.data;
      if (out4.valid && out4.ready) begin
        check("beat_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", out4.data, e.data);
          check("beat_last", out4.last, e.last);
          nbeats++;
        end
      end
      if (in4.valid && in4.ready) void'(in_q.pop_front());
      cycles++;
    end
    if (must_finish) check("run_done", in_q.size() + exp_q.size(), 0);
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    in4.valid = 0;
    in4.last = 0;
    out4.ready = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in4.valid = 0;
    in4.last = 0;
    in4.data = {8'h44, 8'h33, 8'h22, 8'h11};
    out4.ready = 1;
    in1.valid = 0;
    in1.last = 0;
    in1.data = '0;
    out1.ready = 1;
    #12;
    check("rst_out_valid", out4.valid, 0);
    check("rst_out_last", out4.last, 0);
    check("rst_in_ready", in4.ready, 1);
    check("rst_out_data", out4.data, {8'h00, 8'h00, 8'h00, 8'h11});
    in4.valid = 1;
    in1.valid = 1;
    in1.last = 1;
    #1;
    check("rst_valid_follow", out4.valid, 1);
    check("rst_l1_last", out1.last, 0);
    in4.valid = 0;
    in1.valid = 0;
    in1.last = 0;
    @(negedge clock);
    reset = 1;
    add_frame(4, 0, SKEW);
    want = exp_q.size();
    run(-10, -10, 0, 100, 1, cyc, beats);
    check("skew_cycles", cyc, want);
    check("skew_beats", beats, 7);
    idle();
    add_frame(4, 0, DESKEW);
    want = exp_q.size();
    run(-10, -10, 0, 100, 1, cyc, beats);
    check("deskew_cycles", cyc, want);
    idle();
    add_frame(4, 0, SKEW);
    run(2, 8, 1, 100, 1, cyc, beats);
    check("stall_beats", beats, 7);
    idle();
    add_frame(4, 0, SKEW);
    add_frame(3, 100, DESKEW);
    want = exp_q.size();
    run(-10, -10, 1, 100, 1, cyc, beats);
    check("b2b_cycles", cyc, want);
    idle();
    add_frame(4, 100, SKEW);
    run(-10, -10, 0, 5, 0, cyc, beats);
    @(posedge clock);
    #1;
    reset = 0;
    in4.valid = 1;
    in4.last = 0;
    in4.data = {8'h88, 8'h99, 8'haa, 8'h77};
    @(negedge clock);
    check("rstd_out_valid", out4.valid, 1);
    check("rstd_out_last", out4.last, 0);
    check("rstd_out_data", out4.data, {8'h00, 8'h00, 8'h00, 8'h77});
    #2;
    in4.valid = 0;
    reset = 1;
    in_q.delete();
    exp_q.delete();
    add_frame(3, 50, SKEW);
    want = exp_q.size();
    run(-10, -10, 0, 100, 1, cyc, beats);
    check("after_rst_cycles", cyc, want);
    idle();
    @(posedge clock);
    #1;
    in1.valid = 1;
    in1.last = 1;
    in1.data = 8'h5a;
    @(negedge clock);
    check("l1_valid", out1.valid, 1);
    check("l1_last", out1.last, 1);
    check("l1_data", out1.data, 8'h5a);
    check("l1_in_ready", in1.ready, 1);
    @(posedge clock);
    #1;
    in1.last = 0;
    in1.data = 8'hc3;
    @(negedge clock);
    check("l1_state", dut1.state, IDLE);
    check("l1_last_clear", out1.last, 0);
    check("l1_data2", out1.data, 8'hc3);
    check("l1_ready2", in1.ready, 1);
    @(posedge clock);
    #1;
    in1.valid = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
